fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch sequencer for the 6502 core. It reads the architectural `pc` from the register file and drives `next_pc` back to it, so it sits on the opposite end of the pc/next_pc loop.
- It issues byte reads to synchronous program memory and assembles 1-, 2- or 3-byte instructions.
- It presents each complete instruction to the decoder over a valid/ready handshake.
- It accepts redirects from branch/jump logic.

Parameters:
- RESET_PC, 16'h0200, value driven on `next_pc` while `rst` is high.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- pc  input  16  current program counter from the register file.
- next_pc  output  16  program counter for the next cycle, to the register file.
- mem_rd  output  1  program-memory read strobe.
- mem_addr  output  16  program-memory byte address.
- mem_rdata  input  8  read data, valid exactly 1 cycle after `mem_rd`.
- redirect_valid  input  1  discard the current fetch and restart at `redirect_pc`.
- redirect_pc  input  16  redirect target.
- inst_valid  output  1  instruction fields valid.
- inst_ready  input  1  decoder accepts the instruction.
- inst_opcode  output  8  opcode byte.
- inst_operand  output  16  {hi,lo} operand bytes; unused bytes are 0.
- inst_len  output  2  instruction length, 1..3.
- inst_pc  output  16  address of the opcode byte.

Behaviour:
- Clock is `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - FSM goes to REQ_OP.
  - `inst_valid`=0, `mem_rd`=0.
  - `inst_opcode`/`inst_operand`/`inst_pc`=0, `inst_len`=1.
  - While `rst`=1, `next_pc`=RESET_PC combinationally, so `pc`=RESET_PC after the reset edge.
- Default in every state: `next_pc`=`pc` (hold).
- `mem_addr`=`pc` whenever `mem_rd`=1.
- FSM states:
  - REQ_OP: `mem_rd`=1, `next_pc`=`pc`+1, latch `inst_pc`=`pc`, go to CAP_OP.
  - CAP_OP: latch `inst_opcode`=`mem_rdata`. Latch `inst_len`=LEN(`mem_rdata`). Clear the operand. If LEN=1 go to PRESENT, else REQ_B1.
  - REQ_B1: `mem_rd`=1, `next_pc`=`pc`+1, go to CAP_B1.
  - CAP_B1: `inst_operand[7:0]`=`mem_rdata`. If `inst_len`=2 go to PRESENT, else REQ_B2.
  - REQ_B2: `mem_rd`=1, `next_pc`=`pc`+1, go to CAP_B2.
  - CAP_B2: `inst_operand[15:8]`=`mem_rdata`, go to PRESENT.
  - PRESENT: `inst_valid`=1. Fields are stable while `inst_ready`=0. When `inst_ready`=1, go to REQ_OP.
- LEN(op), with cc=op[1:0] and bbb=op[4:2]:
  - Length 1:
    - op[3:0]==8 or op[3:0]==A.
    - op in {00,40,60}.
  - Length 3, any of:
    - op==20;
    - bbb==011;
    - bbb==111;
    - bbb==110 and cc==01.
  - Length 2: everything else, including undocumented opcodes.
- Latency from REQ_OP entry to `inst_valid`: 2 cycles (len 1), 4 cycles (len 2), 6 cycles (len 3).
- `pc` wrap: FFFF+1 = 0000, modulo 2^16. Instructions may straddle the wrap.
- Redirect (`redirect_valid`=1, any state except during `rst`):
  - `next_pc`=`redirect_pc` and `mem_rd`=0 that cycle.
  - Partial instruction is discarded; next state is REQ_OP; `inst_valid`=0 next cycle.
  - In PRESENT with `inst_ready`=1 in the same cycle, the handshake completes (decoder consumed it), then the redirect applies.
- `rst` overrides `redirect_valid`.
- `rst` mid-instruction: collected bytes are dropped and `inst_valid` clears next cycle.
- The unit never reads memory while in PRESENT. Back-pressure costs no extra memory traffic.

Optional Feature:
- FETCH_PERF_EN.
- Defined:
  - Adds outputs `perf_inst_count` [31:0], incremented on each accepted handshake (`inst_valid`&`inst_ready`).
  - Adds `perf_stall_count` [31:0], incremented each cycle `inst_valid`=1 and `inst_ready`=0.
  - Both reset to 0 on `rst` and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then memory 0200: A9 42 8D 00 03 E8, `inst_ready`=1 held. Required handshakes, in order:
  - {opcode A9, operand 0042, len 2, pc 0200}.
  - {8D, 0300, 3, 0202}.
  - {E8, 0000, 1, 0205}.
  - `pc`=0206 after the third.
- Back-pressure: `inst_ready`=0 for 5 cycles on A9 42. Fields stay stable, `mem_rd`=0 throughout, `pc` holds 0202.
  - With FETCH_PERF_EN: `perf_stall_count`=5, and `perf_inst_count`=1 after release.
- Redirect in CAP_B1 of 8D 00 03 with `redirect_pc`=1234, memory 1234: EA. No handshake for 8D; next handshake is {EA, 0000, 1, 1234}.
- Redirect coincident with PRESENT and `inst_ready`=1. The current instruction counts as accepted, and the next fetch starts at `redirect_pc`.
- Wrap: `redirect_pc`=FFFE, memory FFFE: 4C, FFFF: 34, 0000: 12. Required handshake {4C, 1234, 3, FFFE}; `pc`=0001.
- `rst` asserted in REQ_B2. Next cycle `inst_valid`=0. After release `pc`=0200 and the first fetch is from 0200.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer for the 6502 core.
// Reads bytes from synchronous program memory (one-cycle read latency),
// assembles 1/2/3-byte instructions and hands them to the decoder over a
// valid/ready handshake. Drives next_pc back to the register file.
// Optional build macro: FETCH_PERF_EN adds handshake/stall counters.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic [15:0] next_pc,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_opcode,
    output logic [15:0] inst_operand,
    output logic [1:0]  inst_len,
    output logic [15:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_inst_count,
    output logic [31:0] perf_stall_count
`endif
);

    typedef enum logic [2:0] {
        REQ_OP  = 3'd0,
        CAP_OP  = 3'd1,
        REQ_B1  = 3'd2,
        CAP_B1  = 3'd3,
        REQ_B2  = 3'd4,
        CAP_B2  = 3'd5,
        PRESENT = 3'd6
    } state_t;

    state_t      state_q;
    logic        inst_valid_q;
    logic [7:0]  inst_opcode_q;
    logic [15:0] inst_operand_q;
    logic [1:0]  inst_len_q;
    logic [15:0] inst_pc_q;

    logic        in_req;
    logic [1:0]  op_len;
    logic        handshake;

    // Instruction length from the opcode byte. Single-byte forms are checked
    // first; the three-byte forms are absolute/absolute-indexed addressing and
    // JSR; everything else (including undocumented opcodes) takes one operand.
    function automatic logic [1:0] len_of(input logic [7:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        cc  = op[1:0];
        bbb = op[4:2];
        if (op[3:0] == 4'h8 || op[3:0] == 4'hA ||
            op == 8'h00 || op == 8'h40 || op == 8'h60) begin
            len_of = 2'd1;
        end else if (op == 8'h20 || bbb == 3'b011 || bbb == 3'b111 ||
                     (bbb == 3'b110 && cc == 2'b01)) begin
            len_of = 2'd3;
        end else begin
            len_of = 2'd2;
        end
    endfunction

    assign in_req    = (state_q == REQ_OP) || (state_q == REQ_B1) || (state_q == REQ_B2);
    assign op_len    = len_of(mem_rdata);
    assign handshake = inst_valid_q && inst_ready;

    // Memory strobe and pc steering. Reset wins over redirect, redirect wins
    // over the normal byte-request increment; otherwise pc holds.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = pc;
        next_pc  = pc;
        if (rst) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (in_req) begin
            mem_rd  = 1'b1;
            next_pc = pc + 16'd1;
        end
    end

    // Fetch sequencer: request a byte, capture it the following cycle, and
    // present the assembled instruction until the decoder takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= REQ_OP;
            inst_valid_q   <= 1'b0;
            inst_opcode_q  <= 8'h00;
            inst_operand_q <= 16'h0000;
            inst_len_q     <= 2'd1;
            inst_pc_q      <= 16'h0000;
        end else if (redirect_valid) begin
            // Any partial instruction is dropped. In PRESENT with ready high
            // the decoder has already consumed the fields this cycle.
            state_q      <= REQ_OP;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                REQ_OP: begin
                    inst_pc_q <= pc;
                    state_q   <= CAP_OP;
                end
                CAP_OP: begin
                    inst_opcode_q  <= mem_rdata;
                    inst_len_q     <= op_len;
                    inst_operand_q <= 16'h0000;
                    if (op_len == 2'd1) begin
                        inst_valid_q <= 1'b1;
                        state_q      <= PRESENT;
                    end else begin
                        state_q <= REQ_B1;
                    end
                end
                REQ_B1: begin
                    state_q <= CAP_B1;
                end
                CAP_B1: begin
                    inst_operand_q[7:0] <= mem_rdata;
                    if (inst_len_q == 2'd2) begin
                        inst_valid_q <= 1'b1;
                        state_q      <= PRESENT;
                    end else begin
                        state_q <= REQ_B2;
                    end
                end
                REQ_B2: begin
                    state_q <= CAP_B2;
                end
                CAP_B2: begin
                    inst_operand_q[15:8] <= mem_rdata;
                    inst_valid_q         <= 1'b1;
                    state_q              <= PRESENT;
                end
                PRESENT: begin
                    // No memory traffic here: back-pressure only holds state.
                    if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= REQ_OP;
                    end
                end
                default: begin
                    inst_valid_q <= 1'b0;
                    state_q      <= REQ_OP;
                end
            endcase
        end
    end

    assign inst_valid   = inst_valid_q;
    assign inst_opcode  = inst_opcode_q;
    assign inst_operand = inst_operand_q;
    assign inst_len     = inst_len_q;
    assign inst_pc      = inst_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_stall_q;

    // Count accepted instructions and cycles lost to decoder back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (handshake) begin
                perf_inst_q <= perf_inst_q + 32'd1;
            end
            if (inst_valid_q && !inst_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_inst_count  = perf_inst_q;
    assign perf_stall_count = perf_stall_q;
`else
    // Without the counters the handshake term has no consumer.
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with a behavioural pc register, a
// synchronous byte memory and a handshake scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] next_pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [15:0] inst_operand;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_inst_count;
    logic [31:0] perf_stall_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0200)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .next_pc        (next_pc),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_opcode    (inst_opcode),
        .inst_operand   (inst_operand),
        .inst_len       (inst_len),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_inst_count  (perf_inst_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    // Register file pc and synchronous program memory.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        pc <= next_pc;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [7:0]  op;
        logic [15:0] operand;
        logic [1:0]  len;
        logic [15:0] ipc;
    } hs_t;

    typedef struct {
        logic [7:0] op;
        logic [1:0] len;
    } vec_t;

    hs_t  exp_q[$];
    hs_t  mon_e;
    vec_t vecs [0:27];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] opnd,
                        input logic [1:0] len, input logic [15:0] a);
        hs_t e;
        e.op = op; e.operand = opnd; e.len = len; e.ipc = a;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every accepted handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake: got unexpected op=%h opnd=%h len=%0d pc=%h, required none",
                         inst_opcode, inst_operand, inst_len, inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (inst_opcode !== mon_e.op || inst_operand !== mon_e.operand ||
                    inst_len !== mon_e.len || inst_pc !== mon_e.ipc) begin
                    errors++;
                    $display("FAIL handshake: got op=%h opnd=%h len=%0d pc=%h, required op=%h opnd=%h len=%0d pc=%h",
                             inst_opcode, inst_operand, inst_len, inst_pc,
                             mon_e.op, mon_e.operand, mon_e.len, mon_e.ipc);
                end
            end
        end
    end

    task automatic run_until_empty(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d handshakes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        inst_ready = 1'b0;
    endtask

    task automatic redirect_to(input logic [15:0] a);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        for (n = 0; n < 20; n++) begin
            if (inst_valid === 1'b1) break;
            @(posedge clk); #1;
        end
        chk(nm, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_addr(input logic [15:0] a, input string nm);
        int n;
        for (n = 0; n < 20; n++) begin
            if (mem_rd === 1'b1 && mem_addr === a) break;
            @(posedge clk); #1;
        end
        chk(nm, 32'(n < 20), 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  b1, b2;
        logic [15:0] opnd;
        int          lat;

        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        mem[16'h0202] = 8'h8D; mem[16'h0203] = 8'h00; mem[16'h0204] = 8'h03;
        mem[16'h0205] = 8'hE8;
        mem[16'h0300] = 8'h8D; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h03;
        mem[16'h1234] = 8'hEA;
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;

        vecs[0]  = '{8'h00, 2'd1}; vecs[1]  = '{8'h40, 2'd1}; vecs[2]  = '{8'h60, 2'd1};
        vecs[3]  = '{8'h20, 2'd3}; vecs[4]  = '{8'h4C, 2'd3}; vecs[5]  = '{8'h6C, 2'd3};
        vecs[6]  = '{8'hAD, 2'd3}; vecs[7]  = '{8'hBD, 2'd3}; vecs[8]  = '{8'hB9, 2'd3};
        vecs[9]  = '{8'hBE, 2'd3}; vecs[10] = '{8'h19, 2'd3}; vecs[11] = '{8'h1E, 2'd3};
        vecs[12] = '{8'h0C, 2'd3}; vecs[13] = '{8'h9C, 2'd3}; vecs[14] = '{8'hA9, 2'd2};
        vecs[15] = '{8'hA2, 2'd2}; vecs[16] = '{8'h10, 2'd2}; vecs[17] = '{8'h96, 2'd2};
        vecs[18] = '{8'h02, 2'd2}; vecs[19] = '{8'h80, 2'd2}; vecs[20] = '{8'h89, 2'd2};
        vecs[21] = '{8'hB6, 2'd2}; vecs[22] = '{8'h1B, 2'd2}; vecs[23] = '{8'h18, 2'd1};
        vecs[24] = '{8'h9A, 2'd1}; vecs[25] = '{8'h1A, 2'd1}; vecs[26] = '{8'hE8, 2'd1};
        vecs[27] = '{8'h0A, 2'd1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_next_pc", 32'(next_pc), 32'h0200);
        chk("rst_pc", 32'(pc), 32'h0200);
        chk("rst_opcode", 32'(inst_opcode), 32'd0);
        chk("rst_operand", 32'(inst_operand), 32'd0);
        chk("rst_inst_pc", 32'(inst_pc), 32'd0);
        chk("rst_len", 32'(inst_len), 32'd1);
`ifdef FETCH_PERF_EN
        chk("rst_perf_inst", perf_inst_count, 32'd0);
        chk("rst_perf_stall", perf_stall_count, 32'd0);
`endif

        // Straight-line program, ready held high
        push(8'hA9, 16'h0042, 2'd2, 16'h0200);
        push(8'h8D, 16'h0300, 2'd3, 16'h0202);
        push(8'hE8, 16'h0000, 2'd1, 16'h0205);
        @(posedge clk); #1;
        rst = 1'b0;
        inst_ready = 1'b1;
        run_until_empty(100);
        chk("seq_pc_after", 32'(pc), 32'h0206);

        // Back-pressure on A9 42 for five cycles
        do_reset();
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            lat = n;
            if (inst_valid === 1'b1) break;
        end
        chk("len2_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_opcode", 32'(inst_opcode), 32'hA9);
            chk("bp_operand", 32'(inst_operand), 32'h0042);
            chk("bp_len", 32'(inst_len), 32'd2);
            chk("bp_inst_pc", 32'(inst_pc), 32'h0200);
            chk("bp_mem_rd", 32'(mem_rd), 32'd0);
            chk("bp_pc", 32'(pc), 32'h0202);
        end
        push(8'hA9, 16'h0042, 2'd2, 16'h0200);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        run_until_empty(20);
`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall_count, 32'd5);
        chk("perf_inst", perf_inst_count, 32'd1);
`endif

        // Length decode table laid out from 0400
        a = 16'h0400;
        for (int i = 0; i < 28; i++) begin
            b1 = 8'(8'h10 + i);
            b2 = 8'(8'h80 + i);
            mem[a] = vecs[i].op;
            if (vecs[i].len >= 2'd2) mem[a + 16'd1] = b1;
            if (vecs[i].len == 2'd3) mem[a + 16'd2] = b2;
            opnd = (vecs[i].len == 2'd1) ? 16'h0000 :
                   (vecs[i].len == 2'd2) ? {8'h00, b1} : {b2, b1};
            push(vecs[i].op, opnd, vecs[i].len, a);
            a = a + 16'(vecs[i].len);
        end
        redirect_to(16'h0400);
        inst_ready = 1'b1;
        run_until_empty(400);

        // Redirect while capturing the first operand byte of 8D 00 03
        redirect_to(16'h0300);
        inst_ready = 1'b1;
        push(8'hEA, 16'h0000, 2'd1, 16'h1234);
        wait_addr(16'h0301, "reach_req_b1");
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h1234;
        @(negedge clk);
        chk("redir_next_pc", 32'(next_pc), 32'h1234);
        chk("redir_mem_rd", 32'(mem_rd), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("redir_valid_low", 32'(inst_valid), 32'd0);
        run_until_empty(30);

        // Redirect in the same cycle the decoder accepts
        redirect_to(16'h0200);
        wait_valid("present_a9");
        push(8'hA9, 16'h0042, 2'd2, 16'h0200);
        push(8'hEA, 16'h0000, 2'd1, 16'h1234);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h1234;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("redir_hs_valid_low", 32'(inst_valid), 32'd0);
        chk("redir_hs_pc", 32'(pc), 32'h1234);
        run_until_empty(30);

        // Instruction straddling the address wrap
        redirect_to(16'hFFFE);
        push(8'h4C, 16'h1234, 2'd3, 16'hFFFE);
        inst_ready = 1'b1;
        run_until_empty(30);
        chk("wrap_pc", 32'(pc), 32'h0001);

        // Reset while requesting the second operand byte
        redirect_to(16'h0300);
        inst_ready = 1'b1;
        wait_addr(16'h0302, "reach_req_b2");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_next_pc", 32'(next_pc), 32'h0200);
        chk("rst_mid_mem_rd", 32'(mem_rd), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_valid", 32'(inst_valid), 32'd0);
        chk("rst_mid_pc", 32'(pc), 32'h0200);
        @(posedge clk); #1;
        rst = 1'b0;
        push(8'hA9, 16'h0042, 2'd2, 16'h0200);
        @(negedge clk);
        chk("post_rst_mem_rd", 32'(mem_rd), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'h0200);
        run_until_empty(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
